or10_mul_requester: RTL

CPU-side initiator for the OR10 external multiplier port. Accepts a 32x32 multiply request from the execute stage over a valid/ready handshake and drives the 33-bit operand buses to the external multiplier. It holds the operands stable for the multiplier's fixed pipeline latency, captures the 66-bit product, and returns the low and high words plus an overflow flag over a second valid/ready handshake. It sits between the OR10 ALU and the external multiplier instance.

---
 rtl/or10_mul_requester_pkg.sv | 33 +++
 rtl/or10_mul_requester_if.sv | 32 +++
 rtl/or10_mul_requester.sv | 120 ++++++++++++
 3 files changed

// File: rtl/or10_mul_requester_pkg.sv
// Shared types and constants for the OR10 external multiplier requester.
package or10_mul_requester_pkg;

    localparam int unsigned OP_W        = 32;
    localparam int unsigned MOP_W       = 33;
    localparam int unsigned P_W         = 66;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MUL_LAT_MIN = 1;
    localparam int unsigned MUL_LAT_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic            overflow;
        logic [OP_W-1:0] hi;
        logic [OP_W-1:0] lo;
    } rsp_t;

    // Product does not fit in 32 bits under the latched signedness.
    function automatic logic calc_overflow(input logic            is_signed,
                                           input logic [OP_W-1:0] lo,
                                           input logic [OP_W-1:0] hi);
        if (is_signed) begin
            return hi != {OP_W{lo[OP_W-1]}};
        end
        return hi != '0;
    endfunction

endpackage

// File: rtl/or10_mul_requester_if.sv
// Request, response and external-multiplier signals of the OR10 multiply requester.
interface or10_mul_requester_if;
    import or10_mul_requester_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [OP_W-1:0]  req_op_a;
    logic [OP_W-1:0]  req_op_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [OP_W-1:0]  rsp_lo;
    logic [OP_W-1:0]  rsp_hi;
    logic             rsp_overflow;
    logic             busy;
    logic [MOP_W-1:0] mul_a;
    logic [MOP_W-1:0] mul_b;
    logic [P_W-1:0]   mul_p;

    // Requester view.
    modport master (
        input  req_valid, req_signed, req_op_a, req_op_b, rsp_ready, mul_p,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_overflow, busy, mul_a, mul_b
    );

    // Execute stage and multiplier view.
    modport slave (
        output req_valid, req_signed, req_op_a, req_op_b, rsp_ready, mul_p,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_overflow, busy, mul_a, mul_b
    );

endinterface

// File: rtl/or10_mul_requester.sv
// CPU-side initiator for the OR10 external multiplier: holds 33-bit operands for a
// fixed pipeline latency, captures the product and returns lo/hi/overflow.
module or10_mul_requester
    import or10_mul_requester_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    or10_mul_requester_if.master bus
);

    if (MUL_LATENCY < MUL_LAT_MIN || MUL_LATENCY > MUL_LAT_MAX) begin : g_assert_false
        $error("or10_mul_requester: MUL_LATENCY must be within 1..15");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               signed_q, signed_d;
    logic [MOP_W-1:0]   mul_a_q, mul_a_d;
    logic [MOP_W-1:0]   mul_b_q, mul_b_d;
    rsp_t               rsp_q, rsp_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               req_ready_c;
    logic               accept_c;
    logic [1:0]         mul_p_top_unused;

    // Top product bits are outside the 64-bit result.
    assign mul_p_top_unused = bus.mul_p[P_W-1:P_W-2];

    assign req_ready_c = !flush && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_DONE) && bus.rsp_ready));
    assign accept_c    = bus.req_valid && req_ready_c;

    // Next-state, operand and result logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        rsp_d    = rsp_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            mul_a_d = '0;
            mul_b_d = '0;
            rsp_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_WAIT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_d.lo       = bus.mul_p[OP_W-1:0];
                        rsp_d.hi       = bus.mul_p[2*OP_W-1:OP_W];
                        rsp_d.overflow = calc_overflow(signed_q, bus.mul_p[OP_W-1:0],
                                                       bus.mul_p[2*OP_W-1:OP_W]);
                        state_d        = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state_d = ST_IDLE;
                        mul_a_d = '0;
                        mul_b_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Accept only happens in IDLE or on a DONE handshake; overrides the drop to IDLE.
            if (accept_c) begin
                state_d  = ST_WAIT;
                cnt_d    = CNT_W'(MUL_LATENCY);
                signed_d = bus.req_signed;
                mul_a_d  = {bus.req_signed & bus.req_op_a[OP_W-1], bus.req_op_a};
                mul_b_d  = {bus.req_signed & bus.req_op_b[OP_W-1], bus.req_op_b};
            end
        end

        rsp_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            signed_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            signed_q    <= signed_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_lo       = rsp_q.lo;
    assign bus.rsp_hi       = rsp_q.hi;
    assign bus.rsp_overflow = rsp_q.overflow;
    assign bus.busy         = busy_q;
    assign bus.mul_a        = mul_a_q;
    assign bus.mul_b        = mul_b_q;

endmodule
